// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - per-channel synchroniser, debounce and press/release pulse generator
// Optional auto-repeat of press pulses is enabled by defining INPUT_CONDITIONER_AUTOREPEAT_EN.
module input_conditioner #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_PERIOD   = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] signal_in,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic                any_press
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic              IDLE_LVL = (ACTIVE_LOW != 0);

    // Keeps the repeat parameters referenced in builds without auto-repeat.
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic                   level_q, level_d;
        logic                   press_q, press_d;
        logic                   rel_q, rel_d;
        logic                   sample;
        logic                   accept;
        logic                   rpt_fire;

        assign sync_d = {sync_q[SYNC_STAGES-2:0], signal_in[g]};
        assign sample = sync_q[SYNC_STAGES-1] ^ IDLE_LVL;

        always_comb begin
            cnt_d   = cnt_q;
            level_d = level_q;
            accept  = 1'b0;
            if (sample == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                level_d = sample;
                cnt_d   = '0;
                accept  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            // A repeat can only fire while held; an accepted change while held is a release, which wins.
            press_d = (accept & sample) | rpt_fire;
            rel_d   = accept & ~sample;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q  <= {SYNC_STAGES{IDLE_LVL}};
                cnt_q   <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                sync_q  <= sync_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
            end
        end

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
        localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int RPT_W   = $clog2(RPT_MAX + 1);
        localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
        localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

        logic [RPT_W-1:0] rpt_q, rpt_d;
        logic             first_q, first_d;

        // rpt_q counts edges since the last press pulse, minus one.
        always_comb begin
            rpt_d    = '0;
            first_d  = 1'b1;
            rpt_fire = 1'b0;
            if (level_q && !accept) begin
                if (rpt_q == (first_q ? RPT_FIRST : RPT_NEXT)) begin
                    rpt_fire = 1'b1;
                    first_d  = 1'b0;
                end else begin
                    rpt_d   = rpt_q + 1'b1;
                    first_d = first_q;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rpt_q   <= '0;
                first_q <= 1'b1;
            end else begin
                rpt_q   <= rpt_d;
                first_q <= first_d;
            end
        end
`else
        assign rpt_fire = 1'b0;
`endif

        assign level_out[g]     = level_q;
        assign press_pulse[g]   = press_q;
        assign release_pulse[g] = rel_q;
    end

    assign any_press = |press_pulse;

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - scoreboard bench for input_conditioner with default parameters
module tb_input_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] signal_in;
    logic [3:0] level_out;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic       any_press;

    input_conditioner #(
        .CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .ACTIVE_LOW(1),
        .REPEAT_DELAY(50), .REPEAT_PERIOD(10)
    ) dut (
        .clk(clk), .rst(rst), .signal_in(signal_in), .level_out(level_out),
        .press_pulse(press_pulse), .release_pulse(release_pulse), .any_press(any_press)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] level;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse cycle must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst && ((press_pulse | release_pulse) != 4'h0)) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse cyc=%0d press=%h release=%h level=%h", cyc, press_pulse, release_pulse, level_out);
            end else begin
                mon_e = exp_q.pop_front();
                if (cyc != mon_e.cyc || press_pulse != mon_e.press || release_pulse != mon_e.rel ||
                    level_out != mon_e.level || any_press != (|mon_e.press)) begin
                    fails++;
                    $display("FAIL pulse_event got cyc=%0d press=%h release=%h level=%h any=%b expected cyc=%0d press=%h release=%h level=%h any=%b",
                             cyc, press_pulse, release_pulse, level_out, any_press,
                             mon_e.cyc, mon_e.press, mon_e.rel, mon_e.level, |mon_e.press);
                end
            end
        end
    end

    task automatic push(input int c, input logic [3:0] p, input logic [3:0] r, input logic [3:0] l);
        exp_t e;
        e.cyc = c; e.press = p; e.rel = r; e.level = l;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic check4(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    int e0;

    initial begin
        rst       = 1'b1;
        signal_in = 4'hF;
        repeat (3) @(negedge clk);
        check4("reset_level", level_out, 4'h0);
        check4("reset_press", press_pulse, 4'h0);
        check4("reset_release", release_pulse, 4'h0);
        check4("reset_any", {3'b0, any_press}, 4'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Clean press and release on channel 0
        signal_in[0] = 1'b0; e0 = cyc + 1;
        push(e0 + 9, 4'b0001, 4'b0000, 4'b0001);
        wait_cyc(e0 + 10);
        check4("press_one_cycle", press_pulse, 4'h0);
        check4("level_held", level_out, 4'b0001);
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
        // Auto-repeat: held 100 cycles past the first pulse, release lands on a repeat slot
        push(e0 + 59, 4'b0001, 4'b0000, 4'b0001);
        for (int k = 1; k <= 5; k++) push(e0 + 59 + 10 * k, 4'b0001, 4'b0000, 4'b0001);
        wait_cyc(e0 + 9 + 100);
        signal_in[0] = 1'b1;
        push(e0 + 9 + 110, 4'b0000, 4'b0001, 4'b0000);
        wait_cyc(e0 + 9 + 140);
`else
        wait_cyc(e0 + 20);
        signal_in[0] = 1'b1; e0 = cyc + 1;
        push(e0 + 9, 4'b0000, 4'b0001, 4'b0000);
        wait_cyc(e0 + 20);
`endif

        // Bounce on channel 1: 5 low, 1 high, then held low
        signal_in[1] = 1'b0;
        repeat (5) @(negedge clk);
        signal_in[1] = 1'b1;
        @(negedge clk);
        signal_in[1] = 1'b0; e0 = cyc + 1;
        push(e0 + 9, 4'b0010, 4'b0000, 4'b0010);
        wait_cyc(e0 + 20);
        signal_in[1] = 1'b1; e0 = cyc + 1;
        push(e0 + 9, 4'b0000, 4'b0010, 4'b0000);
        wait_cyc(e0 + 20);

        // All channels together
        signal_in = 4'h0; e0 = cyc + 1;
        push(e0 + 9, 4'hF, 4'h0, 4'hF);
        wait_cyc(e0 + 20);
        signal_in = 4'hF; e0 = cyc + 1;
        push(e0 + 9, 4'h0, 4'hF, 4'h0);
        wait_cyc(e0 + 20);

        // Reset mid-debounce on channel 2 with the pin held pressed
        signal_in[2] = 1'b0; e0 = cyc + 1;
        wait_cyc(e0 + 6);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check4("midreset_level", level_out, 4'h0);
        check4("midreset_press", press_pulse, 4'h0);
        rst = 1'b0; e0 = cyc + 1;
        push(e0 + 9, 4'b0100, 4'b0000, 4'b0100);
        wait_cyc(e0 + 20);
        signal_in[2] = 1'b1; e0 = cyc + 1;
        push(e0 + 9, 4'b0000, 4'b0100, 4'b0000);
        wait_cyc(e0 + 30);

        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL missing_pulses got=%0d pending expected=0, next expected cyc=%0d", exp_q.size(), exp_q[0].cyc);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
